mmio_peripherals: RTL and testbench
===================================

Name: mmio_peripherals

Overview:
- Memory-mapped I/O block of the multi-cycle RISC-V microcontroller; occupies the 32-byte window at byte 0x800 of the unified memory map.
- The memory decoder supplies the window offset, write data and write enable, and muxes the read data back to the core.
- Exposes switches, buttons and general input pins as read-only registers.
- Drives LEDs, general output pins and a 4-digit multiplexed seven-segment display from writable registers.

Parameters:
- SCAN_DIV, 100000: clk cycles per display digit slot (1 kHz digit rate at 100 MHz).
- DEB_CYCLES, 65536: consecutive stable cycles required to accept a button change (debounce feature only).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- A  in  5  byte offset within window; decode uses A[4:2], A[1:0] ignored
- WD  in  32  write data
- WE  in  1  write enable, already qualified by the window decode
- RD  out  32  read data, combinational
- sw  in  16  slide switches, asynchronous
- btn  in  5  push buttons, asynchronous
- ipin  in  4  general input pins, asynchronous
- led  out  16  LED register
- opin  out  4  output pin register
- hex  out  7  segments {g,f,e,d,c,b,a}, active-low
- hex_dot  out  1  decimal point, active-low
- hex_sel  out  4  digit anodes, active-low, bit0 = rightmost digit

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous, active-high.
- Inputs: sw, btn, ipin each pass a 2-flop synchronizer (reset to 0). Register reads see pin changes 2 cycles later.
- Register map (word offset A[4:2]); reads are zero-extended:
  - 0 SW (RO) = sw_sync[15:0]
  - 1 BTN (RO) = btn_sync[4:0]
  - 2 IPIN (RO) = ipin_sync[3:0]
  - 3 LED (RW) [15:0]
  - 4 OPIN (RW) [3:0]
  - 5 HEXVAL (RW) [15:0], four nibbles; nibble0 = rightmost digit
  - 6 HEXDOT (RW) [3:0], 1 = dot lit on that digit
  - 7 HEXEN (RW) [3:0], 1 = digit enabled
- Writes: when WE=1 on a clk edge, the addressed RW register loads the low bits of WD; upper WD bits are dropped. Writes to RO offsets are ignored.
- Reads: RD is combinational from A and current register state in the same cycle.
- Outputs: led and opin are driven directly by their registers; the new value is visible the cycle after the write.
- Reset values: LED=0, OPIN=0, HEXVAL=0, HEXDOT=0, HEXEN=4'hF, scan counter=0, digit index=0.
- Scan:
  - Counter counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - For index i: hex = decode(HEXVAL[4i+3:4i]); hex_dot = ~HEXDOT[i]; hex_sel = ~(1<<i) if HEXEN[i], else 4'hF.
  - hex_sel only ever has 0 or 1 bits low.
- Decode (active-low, hex value of {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Write and read of the same register in one cycle: RD returns the old value; the new value is visible next cycle.
- Reset mid-scan: index returns to digit 0 on the next edge.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined:
  - Each synchronized button has a counter. The reported bit changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles.
  - Any glitch back to the reported value clears that counter.
  - Reported bits and counters reset to 0.
- Undefined: BTN reads the synchronized value directly; no counters are instantiated.

Decomposition:
- Shared package holds:
  - register offset constants (OFF_SW..OFF_HEXEN)
  - reset constants, including HEXEN_RST=4'hF
  - the 16-entry segment pattern table
- One natural sub-module: sevenseg_scan, containing the scan counter, digit index, nibble mux, decoder and anode/dot drive.

Test Plan:
- Reset: hold rst 1 cycle → led=0, opin=0, hex_sel=4'b1110, hex=7'h40, hex_dot=1.
- Write LED (A=0x0C, WD=32'hFFFF_A5C3, WE=1) → led=16'hA5C3 next cycle; read A=0x0C → RD=32'h0000_A5C3. Write A=0x00 → no register changes.
- sw=16'h1234, ipin=4'h9 → after 2 cycles, A=0x00 reads 32'h1234 and A=0x08 reads 32'h9. A[1:0]=2'b11 on either offset gives the same RD.
- SCAN_DIV=4, HEXVAL=16'hC0DE, HEXDOT=4'b0100, HEXEN=4'b1011:
  - digit0: hex=06, sel=1110
  - digit1: hex=21, sel=1101
  - digit2: sel=1111, hex=40, dot=0
  - digit3: hex=46, sel=0111
  - index advances every 4 cycles and wraps.
- OPIN: write 32'hFFFF_FFF6 at A=0x10 → opin=4'h6; same-cycle read of A=0x10 returns the old value.
- BTN_DEBOUNCE_EN with DEB_CYCLES=8:
  - btn[2] pulse of 5 cycles → BTN reads 0.
  - btn[2] held 12 cycles → BTN reads 32'h4 from sync+8 cycles on.

Source files
------------

// File: rtl/mmio_peripherals_pkg.sv
// Shared definitions for the MMIO peripheral window: register offsets,
// reset values and the seven-segment pattern table.
package mmio_peripherals_pkg;

    // Word offsets inside the 32-byte window (A[4:2])
    typedef enum logic [2:0] {
        OFF_SW     = 3'd0,
        OFF_BTN    = 3'd1,
        OFF_IPIN   = 3'd2,
        OFF_LED    = 3'd3,
        OFF_OPIN   = 3'd4,
        OFF_HEXVAL = 3'd5,
        OFF_HEXDOT = 3'd6,
        OFF_HEXEN  = 3'd7
    } reg_off_e;

    localparam logic [15:0] LED_RST    = 16'h0000;
    localparam logic [3:0]  OPIN_RST   = 4'h0;
    localparam logic [15:0] HEXVAL_RST = 16'h0000;
    localparam logic [3:0]  HEXDOT_RST = 4'h0;
    localparam logic [3:0]  HEXEN_RST  = 4'hF;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] segDecode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/mmio_peripherals_if.sv
// Memory-decoder side of the peripheral window: offset, write data,
// write enable and the combinational read data returned to the core.
interface mmio_peripherals_if;
    logic [4:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/mmio_peripherals_sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver: a slot counter steps the
// digit index, and the selected nibble, dot and anode are driven active-low.
module sevenseg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexVal_i,
    input  logic [3:0]  hexDot_i,
    input  logic [3:0]  hexEn_i,
    output logic [6:0]  hex_o,
    output logic        hex_dot_o,
    output logic [3:0]  hex_sel_o
);
    import mmio_peripherals_pkg::*;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scanCnt_q, scanCnt_d;
    logic [1:0]    digitIdx_q, digitIdx_d;
    logic [3:0]    nibble;

    // Slot counter wraps at terminal count and moves on to the next digit
    always_comb begin
        scanCnt_d  = scanCnt_q + CW'(1);
        digitIdx_d = digitIdx_q;
        if (scanCnt_q == SCAN_LAST) begin
            scanCnt_d  = '0;
            digitIdx_d = digitIdx_q + 2'd1;
        end
    end

    // Scan state register; reset restarts on the rightmost digit
    always_ff @(posedge clk) begin
        if (rst) begin
            scanCnt_q  <= '0;
            digitIdx_q <= 2'd0;
        end else begin
            scanCnt_q  <= scanCnt_d;
            digitIdx_q <= digitIdx_d;
        end
    end

    // Drive segments, dot and a single low anode (or none if the digit is off)
    always_comb begin
        nibble    = hexVal_i[{digitIdx_q, 2'b00} +: 4];
        hex_o     = segDecode(nibble);
        hex_dot_o = ~hexDot_i[digitIdx_q];
        hex_sel_o = 4'hF;
        if (hexEn_i[digitIdx_q]) begin
            hex_sel_o = ~(4'b0001 << digitIdx_q);
        end
    end

endmodule

// File: rtl/mmio_peripherals.sv
// MMIO peripheral block at byte 0x800: synchronized switch/button/pin
// inputs, LED and output-pin registers, and the seven-segment display.
// Optional macro BTN_DEBOUNCE_EN adds a per-button debounce counter.
module mmio_peripherals #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    mmio_peripherals_if.slave         bus,
    input  logic [15:0]               sw,
    input  logic [4:0]                btn,
    input  logic [3:0]                ipin,
    output logic [15:0]               led,
    output logic [3:0]                opin,
    output logic [6:0]                hex,
    output logic                      hex_dot,
    output logic [3:0]                hex_sel
);
    import mmio_peripherals_pkg::*;

    logic [15:0] swMeta_q, swSync_q;
    logic [4:0]  btnMeta_q, btnSync_q;
    logic [3:0]  ipinMeta_q, ipinSync_q;
    logic [4:0]  btnVal;

    logic [15:0] led_q, led_d;
    logic [3:0]  opin_q, opin_d;
    logic [15:0] hexVal_q, hexVal_d;
    logic [3:0]  hexDot_q, hexDot_d;
    logic [3:0]  hexEn_q, hexEn_d;

    // Byte-lane bits and upper write data are intentionally dropped
    logic unusedBits;
    assign unusedBits = ^{bus.A[1:0], bus.WD[31:16]};

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            swMeta_q   <= '0;
            swSync_q   <= '0;
            btnMeta_q  <= '0;
            btnSync_q  <= '0;
            ipinMeta_q <= '0;
            ipinSync_q <= '0;
        end else begin
            swMeta_q   <= sw;
            swSync_q   <= swMeta_q;
            btnMeta_q  <= btn;
            btnSync_q  <= btnMeta_q;
            ipinMeta_q <= ipin;
            ipinSync_q <= ipinMeta_q;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [4:0]    btnRep_q, btnRep_d;
    logic [DW-1:0] debCnt_q [5];
    logic [DW-1:0] debCnt_d [5];

    // Accept a button change only after it has persisted; any glitch back clears the count
    always_comb begin
        btnRep_d = btnRep_q;
        for (int i = 0; i < 5; i++) begin
            debCnt_d[i] = '0;
            if (btnSync_q[i] != btnRep_q[i]) begin
                if (debCnt_q[i] == DEB_LAST) begin
                    btnRep_d[i] = btnSync_q[i];
                end else begin
                    debCnt_d[i] = debCnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk) begin
        if (rst) begin
            btnRep_q <= '0;
            for (int i = 0; i < 5; i++) debCnt_q[i] <= '0;
        end else begin
            btnRep_q <= btnRep_d;
            for (int i = 0; i < 5; i++) debCnt_q[i] <= debCnt_d[i];
        end
    end

    assign btnVal = btnRep_q;
`else
    assign btnVal = btnSync_q;
`endif

    // Decode a write into the addressed RW register; RO offsets are ignored
    always_comb begin
        led_d    = led_q;
        opin_d   = opin_q;
        hexVal_d = hexVal_q;
        hexDot_d = hexDot_q;
        hexEn_d  = hexEn_q;
        if (bus.WE) begin
            case (reg_off_e'(bus.A[4:2]))
                OFF_LED:    led_d    = bus.WD[15:0];
                OFF_OPIN:   opin_d   = bus.WD[3:0];
                OFF_HEXVAL: hexVal_d = bus.WD[15:0];
                OFF_HEXDOT: hexDot_d = bus.WD[3:0];
                OFF_HEXEN:  hexEn_d  = bus.WD[3:0];
                default:    ;
            endcase
        end
    end

    // Writable register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= LED_RST;
            opin_q   <= OPIN_RST;
            hexVal_q <= HEXVAL_RST;
            hexDot_q <= HEXDOT_RST;
            hexEn_q  <= HEXEN_RST;
        end else begin
            led_q    <= led_d;
            opin_q   <= opin_d;
            hexVal_q <= hexVal_d;
            hexDot_q <= hexDot_d;
            hexEn_q  <= hexEn_d;
        end
    end

    // Read mux reflects current register state, so a same-cycle write reads back old data
    always_comb begin
        bus.RD = '0;
        case (reg_off_e'(bus.A[4:2]))
            OFF_SW:     bus.RD = 32'(swSync_q);
            OFF_BTN:    bus.RD = 32'(btnVal);
            OFF_IPIN:   bus.RD = 32'(ipinSync_q);
            OFF_LED:    bus.RD = 32'(led_q);
            OFF_OPIN:   bus.RD = 32'(opin_q);
            OFF_HEXVAL: bus.RD = 32'(hexVal_q);
            OFF_HEXDOT: bus.RD = 32'(hexDot_q);
            OFF_HEXEN:  bus.RD = 32'(hexEn_q);
            default:    bus.RD = '0;
        endcase
    end

    assign led  = led_q;
    assign opin = opin_q;

    sevenseg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .hexVal_i  (hexVal_q),
        .hexDot_i  (hexDot_q),
        .hexEn_i   (hexEn_q),
        .hex_o     (hex),
        .hex_dot_o (hex_dot),
        .hex_sel_o (hex_sel)
    );

endmodule

// File: tb/tb_mmio_peripherals.sv
// Testbench for mmio_peripherals with a short scan period and short debounce.
module tb_mmio_peripherals;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [3:0]  ipin;
    logic [15:0] led;
    logic [3:0]  opin;
    logic [6:0]  hex;
    logic        hex_dot;
    logic [3:0]  hex_sel;

    int passCount  = 0;
    int checkCount = 0;

    mmio_peripherals_if bus();

    mmio_peripherals #(
        .SCAN_DIV   (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sw      (sw),
        .btn     (btn),
        .ipin    (ipin),
        .led     (led),
        .opin    (opin),
        .hex     (hex),
        .hex_dot (hex_dot),
        .hex_sel (hex_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wA;
        logic [31:0] wD;
        logic        we;
        logic [4:0]  rA;
        logic [31:0] expRd;
        logic [15:0] expLed;
        logic [3:0]  expOpin;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    logic [6:0] expHex [4];
    logic [3:0] expSel [4];
    logic       expDot [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic timeoutFail(input string name);
        checkCount++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] wd, input logic we);
        bus.A  = a;
        bus.WD = wd;
        bus.WE = we;
    endtask

    initial begin
        int waited;

        vecs[0]  = '{5'h0C, 32'hFFFF_A5C3, 1'b1, 5'h0C, 32'h0000_A5C3, 16'hA5C3, 4'h0};
        vecs[1]  = '{5'h00, 32'hFFFF_FFFF, 1'b1, 5'h0C, 32'h0000_A5C3, 16'hA5C3, 4'h0};
        vecs[2]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h00, 32'h0000_1234, 16'hA5C3, 4'h0};
        vecs[3]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h08, 32'h0000_0009, 16'hA5C3, 4'h0};
        vecs[4]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h03, 32'h0000_1234, 16'hA5C3, 4'h0};
        vecs[5]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h0B, 32'h0000_0009, 16'hA5C3, 4'h0};
        vecs[6]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h04, 32'h0000_0000, 16'hA5C3, 4'h0};
        vecs[7]  = '{5'h00, 32'h0000_0000, 1'b0, 5'h1C, 32'h0000_000F, 16'hA5C3, 4'h0};
        vecs[8]  = '{5'h10, 32'hFFFF_FFF6, 1'b1, 5'h10, 32'h0000_0006, 16'hA5C3, 4'h6};
        vecs[9]  = '{5'h18, 32'hFFFF_FFF4, 1'b1, 5'h18, 32'h0000_0004, 16'hA5C3, 4'h6};
        vecs[10] = '{5'h1C, 32'h0000_000B, 1'b1, 5'h1C, 32'h0000_000B, 16'hA5C3, 4'h6};
        vecs[11] = '{5'h14, 32'h1234_C0DE, 1'b1, 5'h14, 32'h0000_C0DE, 16'hA5C3, 4'h6};
        vecs[12] = '{5'h08, 32'h0000_0000, 1'b1, 5'h08, 32'h0000_0009, 16'hA5C3, 4'h6};
        vecs[13] = '{5'h04, 32'hFFFF_FFFF, 1'b1, 5'h04, 32'h0000_0000, 16'hA5C3, 4'h6};
        vecs[14] = '{5'h00, 32'h0000_0000, 1'b0, 5'h0D, 32'h0000_A5C3, 16'hA5C3, 4'h6};

        // HEXVAL=C0DE, HEXDOT=0100, HEXEN=1011
        expHex[0] = 7'h06; expSel[0] = 4'b1110; expDot[0] = 1'b1;
        expHex[1] = 7'h21; expSel[1] = 4'b1101; expDot[1] = 1'b1;
        expHex[2] = 7'h40; expSel[2] = 4'b1111; expDot[2] = 1'b0;
        expHex[3] = 7'h46; expSel[3] = 4'b0111; expDot[3] = 1'b1;

        rst = 1'b1; sw = '0; btn = '0; ipin = '0;
        applyStimulus(5'h00, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset led", 32'(led), 32'h0);
        checkOutput("reset opin", 32'(opin), 32'h0);
        checkOutput("reset hex_sel", 32'(hex_sel), 32'h0000_000E);
        checkOutput("reset hex", 32'(hex), 32'h0000_0040);
        checkOutput("reset hex_dot", 32'(hex_dot), 32'h1);
        rst = 1'b0;

        // Input synchronizer latency
        sw = 16'h1234; ipin = 4'h9;
        tick();
        checkOutput("sw after 1 cycle", bus.RD, 32'h0);
        tick();
        checkOutput("sw after 2 cycles", bus.RD, 32'h0000_1234);
        applyStimulus(5'h08, 32'h0, 1'b0);
        #1;
        checkOutput("ipin after 2 cycles", bus.RD, 32'h0000_0009);

        // Register map vectors
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].wA, vecs[i].wD, vecs[i].we);
            tick();
            applyStimulus(vecs[i].rA, 32'h0, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d rd", i), bus.RD, vecs[i].expRd);
            checkOutput($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].expLed));
            checkOutput($sformatf("vec%0d opin", i), 32'(opin), 32'(vecs[i].expOpin));
        end

        // Same-cycle write and read returns the old value
        applyStimulus(5'h10, 32'h0000_0003, 1'b1);
        #1;
        checkOutput("opin same-cycle rd", bus.RD, 32'h0000_0006);
        checkOutput("opin before edge", 32'(opin), 32'h6);
        tick();
        applyStimulus(5'h10, 32'h0, 1'b0);
        #1;
        checkOutput("opin next-cycle rd", bus.RD, 32'h0000_0003);
        checkOutput("opin next-cycle out", 32'(opin), 32'h3);

        // Align to the first cycle of digit 0
        waited = 0;
        while (hex_sel !== 4'b0111 && waited < 40) begin tick(); waited++; end
        while (hex_sel === 4'b0111 && waited < 40) begin tick(); waited++; end
        if (waited >= 40) timeoutFail("scan align");

        // Two full scan rounds, every cycle of every slot
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) begin
                checkOutput($sformatf("scan s%0d c%0d hex", s, c), 32'(hex), 32'(expHex[s % 4]));
                checkOutput($sformatf("scan s%0d c%0d sel", s, c), 32'(hex_sel), 32'(expSel[s % 4]));
                checkOutput($sformatf("scan s%0d c%0d dot", s, c), 32'(hex_dot), 32'(expDot[s % 4]));
                tick();
            end
        end

        // Reset in the middle of digit 1
        waited = 0;
        while (hex_sel !== 4'b1101 && waited < 40) begin tick(); waited++; end
        if (waited >= 40) timeoutFail("digit1 wait");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midscan reset sel", 32'(hex_sel), 32'h0000_000E);
        checkOutput("midscan reset hex", 32'(hex), 32'h0000_0040);
        checkOutput("midscan reset led", 32'(led), 32'h0);
        checkOutput("midscan reset dot", 32'(hex_dot), 32'h1);

        // Button path
        applyStimulus(5'h04, 32'h0, 1'b0);
        tick();
        tick();
`ifdef BTN_DEBOUNCE_EN
        btn = 5'h04;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("btn pulse %0d", k), bus.RD, 32'h0);
        end
        btn = 5'h00;
        for (int k = 0; k < 15; k++) begin
            tick();
            checkOutput($sformatf("btn after pulse %0d", k), bus.RD, 32'h0);
        end
        btn = 5'h04;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput($sformatf("btn held edge %0d", k), bus.RD, 32'h0);
        end
        for (int k = 10; k <= 12; k++) begin
            tick();
            checkOutput($sformatf("btn held edge %0d", k), bus.RD, 32'h0000_0004);
        end
        btn = 5'h00;
`else
        btn = 5'h04;
        tick();
        checkOutput("btn after 1 cycle", bus.RD, 32'h0);
        tick();
        checkOutput("btn after 2 cycles", bus.RD, 32'h0000_0004);
        btn = 5'h00;
        tick();
        checkOutput("btn release 1 cycle", bus.RD, 32'h0000_0004);
        tick();
        checkOutput("btn release 2 cycles", bus.RD, 32'h0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
